// File: rtl/fb_pkg.sv
// Shared constants, types and the bank address helper for the frame bank manager.
package fb_pkg;

   localparam int FB_NUM_MAX = 8;
   localparam int BANK_W     = 3;
   localparam int ADDR_W     = 32;

   localparam logic [ADDR_W-1:0] DEFAULT_BANK_STRIDE = 32'h0040_0000;

   typedef logic [BANK_W-1:0] bank_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // Byte base of a bank; the sum wraps modulo 2^32 by construction.
   function automatic addr_t bank_addr(input addr_t start, input addr_t stride, input bank_t bank);
      return start + addr_t'(bank) * stride;
   endfunction

endpackage

// File: rtl/fb_free_bank_pick.sv
// Combinational search for the next writer bank: walks W+1, W+2, ... (mod fb_num)
// and returns the first bank that is neither the reader bank nor the latest frame.
module fb_free_bank_pick
   import fb_pkg::*;
(
   input  bank_t             w_bank,
   input  bank_t             r_bank,
   input  bank_t             l_bank,
   input  logic [BANK_W:0]   fb_num,
   output bank_t             next_bank,
   output logic              found
);

   logic [BANK_W:0] sum;
   bank_t           cand;

   // First-match scan; both w_bank and k are below fb_num, so one subtraction wraps the sum.
   always_comb begin
      next_bank = w_bank;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = 1; k < FB_NUM_MAX; k++) begin
         sum = {1'b0, w_bank} + (BANK_W+1)'(k);
         if (sum >= fb_num) begin
            sum = sum - fb_num;
         end
         cand = sum[BANK_W-1:0];
         if (!found && (k < int'(fb_num)) && (cand != r_bank) && (cand != l_bank)) begin
            next_bank = cand;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fb_bank_manager.sv
// Frame bank manager: rotates writer and reader among FB_NUM frame banks,
// tracks the latest complete frame and counts dropped and repeated frames.
module fb_bank_manager
   import fb_pkg::*;
#(
   parameter int              FB_NUM      = 3,
   parameter logic [ADDR_W-1:0] START_ADDR  = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] BANK_STRIDE = DEFAULT_BANK_STRIDE,
   parameter int              CNT_WIDTH   = 16
)
(
   input  logic                  axi_clk,
   input  logic                  axi_clk_rst_n,
   input  logic                  wr_sw,
   input  logic                  rd_sw,
   input  logic                  freeze,
   output logic                  wr_sw_ack,
   output logic                  rd_sw_ack,
   output logic [BANK_W-1:0]     wr_bank,
   output logic [BANK_W-1:0]     rd_bank,
   output logic [ADDR_W-1:0]     wr_start_addr,
   output logic [ADDR_W-1:0]     rd_start_addr,
   output logic                  frame_valid,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic [CNT_WIDTH-1:0]  repeat_cnt
);

   if ((FB_NUM < 2) || (FB_NUM > FB_NUM_MAX)) begin : g_bad_fb_num
      $error("fb_bank_manager: FB_NUM must be in 2..8");
   end

   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("fb_bank_manager: CNT_WIDTH must be at least 1");
   end

   localparam bank_t           LAST_BANK = bank_t'(FB_NUM - 1);
   localparam logic [BANK_W:0] FB_NUM_V  = (BANK_W+1)'(FB_NUM);

   logic  wr_sw_q;
   logic  rd_sw_q;
   bank_t l_bank;
   logic  l_valid;

   logic  wr_edge;
   logic  rd_edge;
   bank_t pick_bank;
   logic  pick_found;
   bank_t w_next;
   bank_t r_next;
   bank_t l_next;
   logic  lv_next;
   logic  drop_inc;
   logic  rep_inc;

   assign wr_edge = wr_sw & ~wr_sw_q;
   assign rd_edge = rd_sw & ~rd_sw_q;

   // After a commit L becomes the current W, so W doubles as the latest-frame input.
   fb_free_bank_pick u_pick (
      .w_bank    (wr_bank),
      .r_bank    (rd_bank),
      .l_bank    (wr_bank),
      .fb_num    (FB_NUM_V),
      .next_bank (pick_bank),
      .found     (pick_found)
   );

   // Next bank state: the write commit is resolved first, then the read sees the updated L/Lv.
   always_comb begin
      w_next   = wr_bank;
      r_next   = rd_bank;
      l_next   = l_bank;
      lv_next  = l_valid;
      drop_inc = 1'b0;
      rep_inc  = 1'b0;
      if (wr_edge) begin
         l_next  = wr_bank;
         lv_next = 1'b1;
         if (pick_found) begin
            w_next = pick_bank;
         end else begin
            lv_next  = 1'b0;
            drop_inc = 1'b1;
         end
      end
      if (rd_edge && !freeze) begin
         if (lv_next && (l_next != rd_bank)) begin
            r_next = l_next;
         end else begin
            rep_inc = 1'b1;
         end
      end
   end

   // Request edge registers and acknowledge pulses.
   always_ff @(posedge axi_clk or negedge axi_clk_rst_n) begin
      if (!axi_clk_rst_n) begin
         wr_sw_q   <= 1'b0;
         rd_sw_q   <= 1'b0;
         wr_sw_ack <= 1'b0;
         rd_sw_ack <= 1'b0;
      end else begin
         wr_sw_q   <= wr_sw;
         rd_sw_q   <= rd_sw;
         wr_sw_ack <= wr_edge;
         rd_sw_ack <= rd_edge;
      end
   end

   // Bank state with addresses registered alongside their bank indices.
   always_ff @(posedge axi_clk or negedge axi_clk_rst_n) begin
      if (!axi_clk_rst_n) begin
         wr_bank       <= '0;
         rd_bank       <= LAST_BANK;
         l_bank        <= '0;
         l_valid       <= 1'b0;
         wr_start_addr <= START_ADDR;
         rd_start_addr <= bank_addr(START_ADDR, BANK_STRIDE, LAST_BANK);
      end else begin
         wr_bank       <= w_next;
         rd_bank       <= r_next;
         l_bank        <= l_next;
         l_valid       <= lv_next;
         wr_start_addr <= bank_addr(START_ADDR, BANK_STRIDE, w_next);
         rd_start_addr <= bank_addr(START_ADDR, BANK_STRIDE, r_next);
      end
   end

   // Sticky frame_valid and saturating drop/repeat statistics.
   always_ff @(posedge axi_clk or negedge axi_clk_rst_n) begin
      if (!axi_clk_rst_n) begin
         frame_valid <= 1'b0;
         drop_cnt    <= '0;
         repeat_cnt  <= '0;
      end else begin
         if (wr_edge) begin
            frame_valid <= 1'b1;
         end
         if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_WIDTH'(1);
         end
         if (rep_inc && (repeat_cnt != '1)) begin
            repeat_cnt <= repeat_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_fb_bank_manager.sv
// Self-checking bench for fb_bank_manager: three instances (FB_NUM 3, 2, 4),
// a directed vector table, hand-written corner sequences and random traffic
// compared against a bank-level reference model.
module tb_fb_bank_manager;

   localparam int NI = 3;
   localparam int          FBN_P    [NI] = '{3, 2, 4};
   localparam logic [31:0] START_P  [NI] = '{32'h0000_0000, 32'h1000_0000, 32'hFFF0_0000};
   localparam logic [31:0] STRIDE_P [NI] = '{32'h0040_0000, 32'h0010_0000, 32'h0040_0000};
   localparam int          CW_P     [NI] = '{16, 3, 4};

   logic        axi_clk = 1'b0;
   logic        axi_clk_rst_n = 1'b1;
   logic        wr_sw    [NI];
   logic        rd_sw    [NI];
   logic        freeze   [NI];
   logic        wr_ack   [NI];
   logic        rd_ack   [NI];
   logic        fv       [NI];
   logic [2:0]  wr_bank  [NI];
   logic [2:0]  rd_bank  [NI];
   logic [31:0] wr_addr  [NI];
   logic [31:0] rd_addr  [NI];
   logic [15:0] drop_cnt [NI];
   logic [15:0] rep_cnt  [NI];

   int checks = 0;
   int errors = 0;

   always #5 axi_clk = ~axi_clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [CW_P[g]-1:0] dc;
      logic [CW_P[g]-1:0] rc;
      fb_bank_manager #(
         .FB_NUM      (FBN_P[g]),
         .START_ADDR  (START_P[g]),
         .BANK_STRIDE (STRIDE_P[g]),
         .CNT_WIDTH   (CW_P[g])
      ) u_dut (
         .axi_clk       (axi_clk),
         .axi_clk_rst_n (axi_clk_rst_n),
         .wr_sw         (wr_sw[g]),
         .rd_sw         (rd_sw[g]),
         .freeze        (freeze[g]),
         .wr_sw_ack     (wr_ack[g]),
         .rd_sw_ack     (rd_ack[g]),
         .wr_bank       (wr_bank[g]),
         .rd_bank       (rd_bank[g]),
         .wr_start_addr (wr_addr[g]),
         .rd_start_addr (rd_addr[g]),
         .frame_valid   (fv[g]),
         .drop_cnt      (dc),
         .repeat_cnt    (rc)
      );
      assign drop_cnt[g] = 16'(dc);
      assign rep_cnt[g]  = 16'(rc);
   end

   // Reference model state, one entry per instance.
   int mW [NI], mR [NI], mL [NI], mDrop [NI], mRep [NI];
   bit mLv [NI], mFv [NI], mPw [NI], mPr [NI], mWack [NI], mRack [NI];

   function automatic logic [31:0] addrOf(int i, int b);
      return START_P[i] + 32'(b) * STRIDE_P[i];
   endfunction

   function automatic int satInc(int v, int i);
      int maxv = (1 << CW_P[i]) - 1;
      return (v < maxv) ? v + 1 : v;
   endfunction

   task automatic modelReset(int i);
      mW[i] = 0; mR[i] = FBN_P[i] - 1; mL[i] = 0; mLv[i] = 0; mFv[i] = 0;
      mDrop[i] = 0; mRep[i] = 0; mPw[i] = 0; mPr[i] = 0; mWack[i] = 0; mRack[i] = 0;
   endtask

   task automatic modelStep(int i, bit wr, bit rd, bit frz);
      bit we, re, found;
      int n, c, nw;
      n = FBN_P[i];
      we = wr && !mPw[i];
      re = rd && !mPr[i];
      mPw[i] = wr; mPr[i] = rd;
      mWack[i] = we; mRack[i] = re;
      if (we) begin
         mL[i] = mW[i]; mLv[i] = 1; mFv[i] = 1;
         found = 0; nw = mW[i];
         for (int k = 1; k < n; k++) begin
            c = (mW[i] + k) % n;
            if (!found && c != mR[i] && c != mL[i]) begin
               nw = c; found = 1;
            end
         end
         if (found) mW[i] = nw;
         else begin
            mLv[i] = 0;
            mDrop[i] = satInc(mDrop[i], i);
         end
      end
      if (re && !frz) begin
         if (mLv[i] && mL[i] != mR[i]) mR[i] = mL[i];
         else mRep[i] = satInc(mRep[i], i);
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one instance for a cycle (others idle) and advance the model past the edge.
   task automatic applyStimulus(int i, bit wr, bit rd, bit frz);
      for (int j = 0; j < NI; j++) begin
         wr_sw[j]  = (j == i) ? wr  : 1'b0;
         rd_sw[j]  = (j == i) ? rd  : 1'b0;
         freeze[j] = (j == i) ? frz : 1'b0;
      end
      @(posedge axi_clk);
      for (int j = 0; j < NI; j++) begin
         if (j == i) modelStep(j, wr, rd, frz);
         else modelStep(j, 1'b0, 1'b0, 1'b0);
      end
      #1;
   endtask

   task automatic checkOutput(int i, string tag);
      chk($sformatf("%s.wr_bank[%0d]", tag, i), 32'(wr_bank[i]), 32'(mW[i]));
      chk($sformatf("%s.rd_bank[%0d]", tag, i), 32'(rd_bank[i]), 32'(mR[i]));
      chk($sformatf("%s.wr_addr[%0d]", tag, i), wr_addr[i], addrOf(i, mW[i]));
      chk($sformatf("%s.rd_addr[%0d]", tag, i), rd_addr[i], addrOf(i, mR[i]));
      chk($sformatf("%s.wr_ack[%0d]", tag, i), 32'(wr_ack[i]), 32'(mWack[i]));
      chk($sformatf("%s.rd_ack[%0d]", tag, i), 32'(rd_ack[i]), 32'(mRack[i]));
      chk($sformatf("%s.fv[%0d]", tag, i), 32'(fv[i]), 32'(mFv[i]));
      chk($sformatf("%s.drop[%0d]", tag, i), 32'(drop_cnt[i]), 32'(mDrop[i]));
      chk($sformatf("%s.rep[%0d]", tag, i), 32'(rep_cnt[i]), 32'(mRep[i]));
      chk($sformatf("%s.w_ne_r[%0d]", tag, i), 32'(wr_bank[i] != rd_bank[i]), 32'd1);
   endtask

   // Asynchronous reset asserted immediately, checked before the next edge, released on negedge.
   task automatic doReset();
      axi_clk_rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         modelReset(i);
         checkOutput(i, "reset");
      end
      @(negedge axi_clk);
      axi_clk_rst_n = 1'b1;
   endtask

   typedef struct {
      bit wr; bit rd; bit frz;
      int eW; int eR; int eDrop; int eRep;
      bit eFv; bit eWack; bit eRack;
   } vec_t;

   vec_t tbl [$];

   initial begin
      for (int j = 0; j < NI; j++) begin
         wr_sw[j] = 1'b0; rd_sw[j] = 1'b0; freeze[j] = 1'b0;
      end
      #2;
      doReset();

      // Directed table on the FB_NUM=3 instance, starting from reset.
      tbl.push_back('{0,1,0, 0,2,0,1, 0,0,1});
      tbl.push_back('{0,0,0, 0,2,0,1, 0,0,0});
      tbl.push_back('{1,0,0, 1,2,0,1, 1,1,0});
      tbl.push_back('{0,0,0, 1,2,0,1, 1,0,0});
      tbl.push_back('{0,1,0, 1,0,0,1, 1,0,1});
      tbl.push_back('{0,0,0, 1,0,0,1, 1,0,0});
      tbl.push_back('{1,0,0, 2,0,0,1, 1,1,0});
      tbl.push_back('{0,0,0, 2,0,0,1, 1,0,0});
      tbl.push_back('{0,1,0, 2,1,0,1, 1,0,1});
      tbl.push_back('{0,0,0, 2,1,0,1, 1,0,0});
      tbl.push_back('{0,1,0, 2,1,0,2, 1,0,1});
      tbl.push_back('{0,0,0, 2,1,0,2, 1,0,0});
      tbl.push_back('{1,1,0, 0,2,0,2, 1,1,1});
      tbl.push_back('{1,0,0, 0,2,0,2, 1,0,0});
      tbl.push_back('{0,0,0, 0,2,0,2, 1,0,0});
      foreach (tbl[n]) begin
         applyStimulus(0, tbl[n].wr, tbl[n].rd, tbl[n].frz);
         chk($sformatf("tbl%0d.wr_bank", n), 32'(wr_bank[0]), 32'(tbl[n].eW));
         chk($sformatf("tbl%0d.rd_bank", n), 32'(rd_bank[0]), 32'(tbl[n].eR));
         chk($sformatf("tbl%0d.wr_addr", n), wr_addr[0], addrOf(0, tbl[n].eW));
         chk($sformatf("tbl%0d.rd_addr", n), rd_addr[0], addrOf(0, tbl[n].eR));
         chk($sformatf("tbl%0d.drop", n), 32'(drop_cnt[0]), 32'(tbl[n].eDrop));
         chk($sformatf("tbl%0d.rep", n), 32'(rep_cnt[0]), 32'(tbl[n].eRep));
         chk($sformatf("tbl%0d.fv", n), 32'(fv[0]), 32'(tbl[n].eFv));
         chk($sformatf("tbl%0d.wr_ack", n), 32'(wr_ack[0]), 32'(tbl[n].eWack));
         chk($sformatf("tbl%0d.rd_ack", n), 32'(rd_ack[0]), 32'(tbl[n].eRack));
      end

      // FB_NUM=2: no free bank exists while the reader holds the other bank.
      doReset();
      applyStimulus(1, 1, 0, 0);
      chk("fb2.c1.wr_bank", 32'(wr_bank[1]), 32'd0);
      chk("fb2.c1.drop", 32'(drop_cnt[1]), 32'd1);
      chk("fb2.c1.fv", 32'(fv[1]), 32'd1);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0);
      chk("fb2.c2.wr_bank", 32'(wr_bank[1]), 32'd0);
      chk("fb2.c2.drop", 32'(drop_cnt[1]), 32'd2);
      chk("fb2.c2.fv", 32'(fv[1]), 32'd1);
      checkOutput(1, "fb2");
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1, 0, 0, 0);
         applyStimulus(1, 1, 0, 0);
      end
      chk("fb2.sat.drop", 32'(drop_cnt[1]), 32'd7);

      // FB_NUM=4: simultaneous write and read; addresses wrap past 2^32.
      doReset();
      applyStimulus(2, 1, 1, 0);
      chk("fb4.both.wr_ack", 32'(wr_ack[2]), 32'd1);
      chk("fb4.both.rd_ack", 32'(rd_ack[2]), 32'd1);
      chk("fb4.both.rd_bank", 32'(rd_bank[2]), 32'd0);
      chk("fb4.both.wr_bank", 32'(wr_bank[2]), 32'd1);
      chk("fb4.both.wr_addr", wr_addr[2], 32'h0030_0000);
      chk("fb4.both.rd_addr", rd_addr[2], 32'hFFF0_0000);
      checkOutput(2, "fb4");

      // Freeze across three write/read rounds, then reset with a write still held.
      doReset();
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 0, 1);
         applyStimulus(0, 0, 0, 1);
         applyStimulus(0, 0, 1, 1);
         chk($sformatf("frz%0d.rd_ack", k), 32'(rd_ack[0]), 32'd1);
         applyStimulus(0, 0, 0, 1);
         chk($sformatf("frz%0d.rd_bank", k), 32'(rd_bank[0]), 32'd0);
         chk($sformatf("frz%0d.rep", k), 32'(rep_cnt[0]), 32'd0);
         chk($sformatf("frz%0d.drop", k), 32'(drop_cnt[0]), 32'd0);
         checkOutput(0, "frz");
      end
      applyStimulus(0, 1, 0, 1);
      #2;
      doReset();
      chk("rst.wr_bank", 32'(wr_bank[0]), 32'd0);
      chk("rst.rd_bank", 32'(rd_bank[0]), 32'd2);
      chk("rst.rd_addr", rd_addr[0], 32'h0080_0000);
      chk("rst.fv", 32'(fv[0]), 32'd0);
      applyStimulus(0, 1, 0, 0);
      chk("rst.rel.wr_ack", 32'(wr_ack[0]), 32'd1);
      chk("rst.rel.wr_bank", 32'(wr_bank[0]), 32'd1);
      chk("rst.rel.fv", 32'(fv[0]), 32'd1);

      // Random traffic on every instance against the model.
      for (int i = 0; i < NI; i++) begin
         doReset();
         for (int c = 0; c < 400; c++) begin
            applyStimulus(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0));
            checkOutput(i, "rnd");
            if ($urandom_range(0, 149) == 0) doReset();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
